comparison_operand_generator: RTL and testbench



---
 rtl/comparator_pkg.sv | 41 ++++
 rtl/lfsr_galois.sv | 40 ++++
 rtl/comparison_operand_generator.sv | 245 ++++++++++++++++++++++++
 tb/tb_comparison_operand_generator.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// ----------------------------------------------------------------------------
// comparator_pkg
//
// Types and constants shared by the comparator family and by the
// comparison operand generator.
//
//   relation_t  : relation encoding carried on Relation_In
//                 (LT / EQ / GT, with 2'b11 reserved as invalid)
//   gen_state_t : operand generator control states
//   DEFAULT_LFSR_SEED / DEFAULT_LFSR_TAPS : 16-bit Galois LFSR defaults,
//                 polynomial x^16 + x^14 + x^13 + x^11 + 1
//   MAX_DATA_WIDTH : widest operand the generator is defined for
//   is_valid_relation() : true for LT, EQ and GT
// ----------------------------------------------------------------------------
package comparator_pkg;

    typedef enum logic [1:0] {
        REL_LT  = 2'b00,
        REL_EQ  = 2'b01,
        REL_GT  = 2'b10,
        REL_INV = 2'b11
    } relation_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRAW   = 2'b01,
        ADJUST = 2'b10,
        HOLD   = 2'b11
    } gen_state_t;

    localparam int          MAX_DATA_WIDTH    = 8;
    localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form: the bit shifted out of bit 0 is XORed
    // into the tap positions for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] DEFAULT_LFSR_TAPS = 16'hB400;

    function automatic logic is_valid_relation(input logic [1:0] rel);
        return rel != REL_INV;
    endfunction

endpackage : comparator_pkg

// File: rtl/lfsr_galois.sv
// ----------------------------------------------------------------------------
// lfsr_galois
//
// Free-running right-shifting Galois LFSR. Every rising edge outside reset
// the register shifts right by one; when the bit leaving position 0 is set,
// the TAPS mask is XORed into the shifted value.
//
// Parameters:
//   WIDTH : register length (>= 2)
//   SEED  : reset value, must be non-zero or the register locks at zero
//   TAPS  : feedback mask for the chosen polynomial
//
// Ports:
//   Clock_In  : clock, rising edge
//   Reset_In  : synchronous active-high reset, reloads SEED
//   Lfsr_Out  : current register contents
// ----------------------------------------------------------------------------
module lfsr_galois
    import comparator_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_LFSR_SEED),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_LFSR_TAPS)
) (
    input  logic             Clock_In,
    input  logic             Reset_In,
    output logic [WIDTH-1:0] Lfsr_Out
);

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            Lfsr_Out <= SEED;
        end else begin
            Lfsr_Out <= {1'b0, Lfsr_Out[WIDTH-1:1]} ^ (Lfsr_Out[0] ? TAPS : '0);
        end
    end

endmodule : lfsr_galois

// File: rtl/comparison_operand_generator.sv
// ----------------------------------------------------------------------------
// comparison_operand_generator
//
// Inverse of the comparator: given a requested relation (LT / EQ / GT) it
// produces an operand pair (A, B) that satisfies it. Raw operands come from
// a free-running Galois LFSR and are corrected deterministically:
//   EQ : B = A
//   LT : keep if A < B, swap if A > B; on A == B bump B up, or A down when
//        B is already at the maximum value
//   GT : mirror of LT (bump A up, or B down when A is at the maximum)
// No arithmetic ever wraps.
//
// Flow: IDLE accepts a request -> DRAW captures raw A/B -> ADJUST loads the
// corrected pair and raises Data_Valid_Out -> HOLD keeps the pair stable
// until the downstream handshake, then back to IDLE. Data_Valid_Out rises
// two cycles after the accepting edge; minimum request period is 4 cycles.
// An invalid relation (2'b11) is accepted in IDLE, pulses Error_Out for one
// cycle and produces no data.
//
// Parameters:
//   DATA_WIDTH : operand width, 1..8
//   LFSR_WIDTH : LFSR length, at least 2*DATA_WIDTH
//   LFSR_SEED  : LFSR reset value, non-zero
//   LFSR_TAPS  : LFSR feedback mask; the default matches LFSR_WIDTH = 16
//
// Ports:
//   Clock_In          : clock, rising edge
//   Reset_In          : synchronous active-high reset
//   Request_Valid_In  : relation request present
//   Relation_In       : 00 LT, 01 EQ, 10 GT, 11 invalid
//   Request_Ready_Out : high only in IDLE
//   Data_A_Out        : generated operand A
//   Data_B_Out        : generated operand B
//   Data_Valid_Out    : operand pair valid
//   Data_Ready_In     : downstream accepts the pair
//   Error_Out         : one-cycle pulse after an invalid relation is accepted
//   Pair_Count_Out    : (PAIR_COUNT_EN only) 16-bit wrapping count of
//                       output handshakes
//
// Configuration macro: PAIR_COUNT_EN adds Pair_Count_Out and its counter.
// ----------------------------------------------------------------------------
module comparison_operand_generator
    import comparator_pkg::*;
#(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    LFSR_WIDTH = 16,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = LFSR_WIDTH'(DEFAULT_LFSR_SEED),
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = LFSR_WIDTH'(DEFAULT_LFSR_TAPS)
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Request_Valid_In,
    input  logic [1:0]            Relation_In,
    output logic                  Request_Ready_Out,
    output logic [DATA_WIDTH-1:0] Data_A_Out,
    output logic [DATA_WIDTH-1:0] Data_B_Out,
    output logic                  Data_Valid_Out,
    input  logic                  Data_Ready_In,
    output logic                  Error_Out
`ifdef PAIR_COUNT_EN
    ,
    output logic [15:0]           Pair_Count_Out
`endif
);

    localparam logic [DATA_WIDTH-1:0] MAX_VALUE = '1;

    gen_state_t              state;
    gen_state_t              state_next;
    relation_t               relation_q;
    logic [LFSR_WIDTH-1:0]   lfsr_value;
    logic [DATA_WIDTH-1:0]   raw_a;
    logic [DATA_WIDTH-1:0]   raw_b;
    logic [DATA_WIDTH-1:0]   adj_a;
    logic [DATA_WIDTH-1:0]   adj_b;
    logic                    accept;
    logic                    capture_raw;
    logic                    load_pair;
    logic                    handshake;

    // ------------------------------------------------------------------
    // Operand source: advances every cycle regardless of FSM state.
    // ------------------------------------------------------------------
    lfsr_galois #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .Clock_In (Clock_In),
        .Reset_In (Reset_In),
        .Lfsr_Out (lfsr_value)
    );

    // Only the low 2*DATA_WIDTH bits feed the operands.
    if (LFSR_WIDTH > 2 * DATA_WIDTH) begin : g_spare_lfsr_bits
        logic unused_lfsr_bits;
        assign unused_lfsr_bits = ^lfsr_value[LFSR_WIDTH-1:2*DATA_WIDTH];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Invalid relations are accepted but keep the
    // FSM in IDLE.
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default at the top of the
    // block, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (Request_Valid_In && is_valid_relation(Relation_In)) begin
                    state_next = DRAW;
                end
            end
            DRAW:   state_next = ADJUST;
            ADJUST: state_next = HOLD;
            HOLD: begin
                if (Data_Valid_Out && Data_Ready_In) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath strobes
    // ------------------------------------------------------------------
    always_comb begin
        Request_Ready_Out = 1'b0;
        capture_raw       = 1'b0;
        load_pair         = 1'b0;
        handshake         = 1'b0;
        unique case (state)
            IDLE:    Request_Ready_Out = 1'b1;
            DRAW:    capture_raw       = 1'b1;
            ADJUST:  load_pair         = 1'b1;
            HOLD:    handshake         = Data_Valid_Out && Data_Ready_In;
            default: ;
        endcase
    end

    assign accept = Request_Ready_Out && Request_Valid_In;

    // ------------------------------------------------------------------
    // Correction of the raw pair so it satisfies the latched relation.
    // Ties are broken towards the side that still has headroom, so the
    // +1 / -1 never wraps.
    // ------------------------------------------------------------------
    always_comb begin
        adj_a = raw_a;
        adj_b = raw_b;
        unique case (relation_q)
            REL_EQ: begin
                adj_b = raw_a;
            end
            REL_LT: begin
                if (raw_a > raw_b) begin
                    adj_a = raw_b;
                    adj_b = raw_a;
                end else if (raw_a == raw_b) begin
                    if (raw_b != MAX_VALUE) begin
                        adj_b = raw_b + DATA_WIDTH'(1);
                    end else begin
                        adj_a = raw_a - DATA_WIDTH'(1);
                    end
                end
            end
            REL_GT: begin
                if (raw_a < raw_b) begin
                    adj_a = raw_b;
                    adj_b = raw_a;
                end else if (raw_a == raw_b) begin
                    if (raw_a != MAX_VALUE) begin
                        adj_a = raw_a + DATA_WIDTH'(1);
                    end else begin
                        adj_b = raw_b - DATA_WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            relation_q     <= REL_LT;
            raw_a          <= '0;
            raw_b          <= '0;
            Data_A_Out     <= '0;
            Data_B_Out     <= '0;
            Data_Valid_Out <= 1'b0;
            Error_Out      <= 1'b0;
        end else begin
            // High for exactly the cycle after an invalid request is taken.
            Error_Out <= accept && !is_valid_relation(Relation_In);

            if (accept) begin
                relation_q <= relation_t'(Relation_In);
            end

            if (capture_raw) begin
                raw_a <= lfsr_value[DATA_WIDTH-1:0];
                raw_b <= lfsr_value[2*DATA_WIDTH-1:DATA_WIDTH];
            end

            // Operands keep their last values after the handshake; only
            // the valid flag drops.
            if (load_pair) begin
                Data_A_Out     <= adj_a;
                Data_B_Out     <= adj_b;
                Data_Valid_Out <= 1'b1;
            end else if (handshake) begin
                Data_Valid_Out <= 1'b0;
            end
        end
    end

`ifdef PAIR_COUNT_EN
    // ------------------------------------------------------------------
    // Optional count of delivered pairs; wraps naturally at 16 bits.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            Pair_Count_Out <= '0;
        end else if (handshake) begin
            Pair_Count_Out <= Pair_Count_Out + 16'd1;
        end
    end
`endif

endmodule : comparison_operand_generator

// File: tb/tb_comparison_operand_generator.sv
// ----------------------------------------------------------------------------
// tb_comparison_operand_generator
//
// Scoreboard bench for comparison_operand_generator (DATA_WIDTH = 2).
// The stimulus side predicts each pair from a reference LFSR and the
// relation rules, and queues it with the cycle on which Data_Valid_Out must
// rise. A separate monitor on the falling edge pops and compares, and also
// checks hold stability, the handshake drop, Error_Out pulses and reset
// values. Build with +define+PAIR_COUNT_EN to also check Pair_Count_Out.
// ----------------------------------------------------------------------------
module tb_comparison_operand_generator;
    import comparator_pkg::*;

    localparam int          DATA_WIDTH = 2;
    localparam int          MAX_VAL    = (1 << DATA_WIDTH) - 1;
    localparam logic [15:0] SEED       = 16'hACE1;

    typedef struct {
        int     rel;
        int     a;
        int     b;
        longint due;
    } pair_exp_t;

    logic                  Clock_In         = 1'b0;
    logic                  Reset_In         = 1'b1;
    logic                  Request_Valid_In = 1'b0;
    logic [1:0]            Relation_In      = 2'b00;
    logic                  Request_Ready_Out;
    logic [DATA_WIDTH-1:0] Data_A_Out;
    logic [DATA_WIDTH-1:0] Data_B_Out;
    logic                  Data_Valid_Out;
    logic                  Data_Ready_In    = 1'b1;
    logic                  Error_Out;
`ifdef PAIR_COUNT_EN
    logic [15:0]           Pair_Count_Out;
    int                    exp_count = 0;
`endif

    int          checks  = 0;
    int          errors  = 0;
    longint      cyc     = 0;
    logic [15:0] m_lfsr  = SEED;
    int          bp_mode = 0;   // 0: ready high, 1: random, 2: ready low

    pair_exp_t   exp_q[$];
    longint      err_q[$];
    pair_exp_t   cur_exp = '{rel: 0, a: 0, b: 0, due: 0};

    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_rst   = 1'b1;

    comparison_operand_generator #(
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .Clock_In          (Clock_In),
        .Reset_In          (Reset_In),
        .Request_Valid_In  (Request_Valid_In),
        .Relation_In       (Relation_In),
        .Request_Ready_Out (Request_Ready_Out),
        .Data_A_Out        (Data_A_Out),
        .Data_B_Out        (Data_B_Out),
        .Data_Valid_Out    (Data_Valid_Out),
        .Data_Ready_In     (Data_Ready_In),
        .Error_Out         (Error_Out)
`ifdef PAIR_COUNT_EN
        ,
        .Pair_Count_Out    (Pair_Count_Out)
`endif
    );

    always #5 Clock_In = ~Clock_In;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic out_bit;
        out_bit = v[0];
        v = v >> 1;
        if (out_bit) v = v ^ 16'hB400;
        return v;
    endfunction

    function automatic pair_exp_t ref_pair(input int rel, input int a, input int b);
        pair_exp_t p;
        p = '{rel: rel, a: a, b: b, due: 0};
        if (rel == REL_EQ) begin
            p.b = a;
        end else if (rel == REL_LT) begin
            if (a > b) begin
                p.a = b; p.b = a;
            end else if (a == b) begin
                if (b != MAX_VAL) p.b = b + 1;
                else              p.a = a - 1;
            end
        end else if (rel == REL_GT) begin
            if (a < b) begin
                p.a = b; p.b = a;
            end else if (a == b) begin
                if (a != MAX_VAL) p.a = a + 1;
                else              p.b = b - 1;
            end
        end
        return p;
    endfunction

    function automatic int rel_of(input int a, input int b);
        if (a < b)  return 0;
        if (a == b) return 1;
        return 2;
    endfunction

    // Reference LFSR and cycle counter, following the DUT's reset.
    always @(posedge Clock_In) begin
        cyc = cyc + 1;
        if (Reset_In) m_lfsr = SEED;
        else          m_lfsr = lfsr_next(m_lfsr);
    end

    // Downstream ready generator, driven after the driver's own updates.
    always @(posedge Clock_In) begin
        #2;
        case (bp_mode)
            0:       Data_Ready_In = 1'b1;
            1:       Data_Ready_In = ($urandom_range(0, 3) != 0);
            default: Data_Ready_In = 1'b0;
        endcase
    end

    // Called 1 time unit after a rising edge. Waits for ready, presents the
    // request for one edge and queues the expected response.
    task automatic issue(input logic [1:0] rel, input int force_a = -1,
                         input int force_b = -1);
        int          waited;
        logic [15:0] draw;
        pair_exp_t   p;
        waited = 0;
        while (Request_Ready_Out !== 1'b1 && waited < 60) begin
            @(posedge Clock_In); #1;
            waited++;
        end
        check("ready_before_request", Request_Ready_Out, 1'b1);
        if (Request_Ready_Out !== 1'b1) return;

        Request_Valid_In = 1'b1;
        Relation_In      = rel;
        // Raw operands are captured one edge after acceptance, i.e. from
        // the LFSR value that follows the current one.
        draw = lfsr_next(m_lfsr);
        if (rel == REL_INV) begin
            err_q.push_back(cyc + 1);
        end else begin
            p = ref_pair(int'(rel), int'(draw[DATA_WIDTH-1:0]),
                         int'(draw[2*DATA_WIDTH-1:DATA_WIDTH]));
            if (force_a >= 0) begin
                p.a = force_a;
                p.b = force_b;
            end
            p.due = cyc + 3;
            exp_q.push_back(p);
        end
        @(posedge Clock_In); #1;
        Request_Valid_In = 1'b0;
        if (rel == REL_INV) check("ready_after_invalid", Request_Ready_Out, 1'b1);
        else                check("ready_after_accept", Request_Ready_Out, 1'b0);
    endtask

    // Waits until the reference LFSR predicts a raw draw of A = B = MAX,
    // then issues the request so the tie-at-maximum correction is exercised.
    task automatic issue_forced(input logic [1:0] rel, input int exp_a, input int exp_b);
        logic [15:0] nxt;
        int          waited;
        logic        found;
        waited = 0;
        found  = 1'b0;
        while (Request_Ready_Out !== 1'b1 && waited < 60) begin
            @(posedge Clock_In); #1;
            waited++;
        end
        waited = 0;
        while (!found && waited < 1000) begin
            nxt = lfsr_next(m_lfsr);
            if (int'(nxt[DATA_WIDTH-1:0]) == MAX_VAL &&
                int'(nxt[2*DATA_WIDTH-1:DATA_WIDTH]) == MAX_VAL) begin
                found = 1'b1;
            end else begin
                @(posedge Clock_In); #1;
                waited++;
            end
        end
        check("forced_tie_draw_found", found, 1'b1);
        if (found) issue(rel, exp_a, exp_b);
    endtask

    // Monitor: everything sampled on the falling edge.
    always @(negedge Clock_In) begin
        pair_exp_t p;
        logic      exp_err;
        if (prev_rst) begin
            check("reset_valid", Data_Valid_Out, 1'b0);
            check("reset_ready", Request_Ready_Out, 1'b1);
            check("reset_error", Error_Out, 1'b0);
            check("reset_a", Data_A_Out, 0);
            check("reset_b", Data_B_Out, 0);
`ifdef PAIR_COUNT_EN
            exp_count = 0;
            check("reset_pair_count", Pair_Count_Out, exp_count);
`endif
        end else begin
            exp_err = 1'b0;
            if (err_q.size() > 0 && err_q[0] == cyc) begin
                exp_err = 1'b1;
                void'(err_q.pop_front());
            end
            check("error_pulse", Error_Out, exp_err);

            if (prev_valid && prev_ready) begin
                check("valid_drop_after_handshake", Data_Valid_Out, 1'b0);
                check("a_kept_after_handshake", Data_A_Out, cur_exp.a);
                check("b_kept_after_handshake", Data_B_Out, cur_exp.b);
`ifdef PAIR_COUNT_EN
                exp_count = (exp_count + 1) % 65536;
                check("pair_count", Pair_Count_Out, exp_count);
`endif
            end else if (prev_valid) begin
                check("hold_valid", Data_Valid_Out, 1'b1);
                check("hold_a", Data_A_Out, cur_exp.a);
                check("hold_b", Data_B_Out, cur_exp.b);
            end

            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                p = exp_q.pop_front();
                cur_exp = p;
                check("valid_rise_latency", {prev_valid, Data_Valid_Out}, 2'b01);
                check("operand_a", Data_A_Out, p.a);
                check("operand_b", Data_B_Out, p.b);
                check("relation_holds",
                      rel_of(int'(Data_A_Out), int'(Data_B_Out)), p.rel);
            end else if (Data_Valid_Out && !prev_valid) begin
                check("unexpected_valid", Data_Valid_Out, 1'b0);
            end
        end
        prev_valid = Data_Valid_Out;
        prev_ready = Data_Ready_In;
        prev_rst   = Reset_In;
    end

    initial begin
        // Reset held for two edges.
        repeat (2) @(posedge Clock_In);
        #1;
        Reset_In = 1'b0;
        repeat (2) @(posedge Clock_In);
        #1;

        // EQ requests with the downstream always ready.
        for (int i = 0; i < 50; i++) issue(REL_EQ);

        // LT and GT, 200 each, random gaps and random downstream stalls.
        bp_mode = 1;
        for (int i = 0; i < 400; i++) begin
            issue((i % 2 == 0) ? REL_LT : REL_GT);
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clock_In); #1;
            end
        end
        bp_mode = 0;
        repeat (12) begin
            @(posedge Clock_In); #1;
        end

        // Raw tie at the maximum value.
        issue_forced(REL_LT, 2, 3);
        issue_forced(REL_GT, 3, 2);

        // Invalid relation: error pulse only.
        issue(REL_INV);
        repeat (3) begin
            @(posedge Clock_In); #1;
        end
        check("ready_idle_after_error", Request_Ready_Out, 1'b1);

        // Downstream stall: pair held, concurrent request refused.
        bp_mode = 2;
        repeat (2) begin
            @(posedge Clock_In); #1;
        end
        issue(REL_LT);
        for (int w = 0; w < 10 && Data_Valid_Out !== 1'b1; w++) begin
            @(posedge Clock_In); #1;
        end
        check("stall_valid_seen", Data_Valid_Out, 1'b1);
        for (int j = 0; j < 10; j++) begin
            Request_Valid_In = 1'b1;
            Relation_In      = REL_GT;
            check("ready_low_in_hold", Request_Ready_Out, 1'b0);
            @(posedge Clock_In); #1;
        end
        Request_Valid_In = 1'b0;
        bp_mode = 0;
        repeat (6) begin
            @(posedge Clock_In); #1;
        end

        // Reset while in ADJUST: pending pair discarded.
        issue(REL_EQ);
        @(posedge Clock_In); #1;
        Reset_In = 1'b1;
        exp_q.delete();
        @(posedge Clock_In); #1;
        Reset_In = 1'b0;
        @(posedge Clock_In); #1;

        // Normal operation after the reseed.
        for (int i = 0; i < 6; i++) issue(2'($urandom_range(0, 2)));

        repeat (10) begin
            @(posedge Clock_In); #1;
        end
        check("pairs_outstanding", exp_q.size(), 0);
        check("errors_outstanding", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_comparison_operand_generator
